// File: rtl/ram_fifo_ctrl_if.sv
// Stream bundle for ram_fifo_ctrl: write stream (s_*) in, read stream (m_*) out.
// Latency: none, wires only.
// Backpressure: s_ready / m_ready carry valid/ready flow control in each direction.
// Ports: s_valid/s_ready/s_data (write side), m_valid/m_ready/m_data (read side).
// Modports: master = producer/consumer side, slave = controller side.
interface ram_fifo_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FWFT FIFO controller around a 16x8 RAM with separate write (port 0) and read (port 1) ports.
// Latency: word accepted at edge T shows as m_valid after edge T+2; one word/cycle each side.
// Backpressure: s_ready = !ram_full from registered state; 2-entry skid absorbs the RAM read latency.
// Ports: clk, rst_n (async, active low), clr (sync flush), io (stream bundle, slave side),
//        ram_wr_* / ram_rd_* (RAM strobes, addresses, data), count (RAM + in-flight + skid).
// Optional: define RAM_FIFO_CTRL_ALMOST_FULL_EN to add the registered almost_full output and AF_LEVEL.
module ram_fifo_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4
`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
    ,
    parameter int AF_LEVEL = 12
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    ram_fifo_ctrl_if.slave      io,
    output logic                ram_wr_en,
    output logic [ADDR_W-1:0]   ram_wr_addr,
    output logic [DATA_W-1:0]   ram_wr_data,
    output logic                ram_rd_en,
    output logic [ADDR_W-1:0]   ram_rd_addr,
    input  logic [DATA_W-1:0]   ram_rd_data,
`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
    output logic                almost_full,
`endif
    output logic [ADDR_W+1:0]   count
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_W:0]     wr_ptr;
    logic [ADDR_W:0]     rd_ptr;
    logic [ADDR_W:0]     ram_count;
    logic                ram_full;
    logic                ram_empty;
    logic                rd_inflight;
    logic [1:0]          skid_cnt;
    logic [DATA_W-1:0]   skid_head;
    logic [DATA_W-1:0]   skid_tail;
    logic                wr_fire;
    logic                pop;
    logic                push;
    logic [2:0]          skid_occ;

    assign ram_count = wr_ptr - rd_ptr;
    assign ram_full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                       (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign ram_empty = (wr_ptr == rd_ptr);

    // s_ready depends only on pointer state (and reset), never on s_valid or m_ready.
    assign io.s_ready = rst_n & ~ram_full;
    assign io.m_valid = (skid_cnt != 2'd0);
    assign io.m_data  = skid_head;

    assign wr_fire     = io.s_valid & io.s_ready & ~clr;
    assign ram_wr_en   = wr_fire;
    assign ram_wr_addr = wr_ptr[ADDR_W-1:0];
    assign ram_wr_data = io.s_data;

    assign pop  = io.m_valid & io.m_ready;
    assign push = rd_inflight;

    // Issue a read only if the skid will have room when the data lands next cycle:
    // entries held + the read already in flight, less the pop happening now, must be < 2.
    assign skid_occ    = {1'b0, skid_cnt} + {2'b00, rd_inflight};
    assign ram_rd_en   = ~ram_empty & ~clr & (skid_occ < (3'd2 + {2'b00, pop}));
    assign ram_rd_addr = rd_ptr[ADDR_W-1:0];

    assign count = {1'b0, ram_count}
                 + {{(ADDR_W+1){1'b0}}, rd_inflight}
                 + {{ADDR_W{1'b0}}, skid_cnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rd_inflight <= 1'b0;
            skid_cnt    <= 2'd0;
            skid_head   <= '0;
            skid_tail   <= '0;
        end else if (clr) begin
            // Flush drops the concurrent write and whatever the RAM is returning.
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rd_inflight <= 1'b0;
            skid_cnt    <= 2'd0;
            skid_head   <= '0;
            skid_tail   <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
            end
            if (ram_rd_en) begin
                rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
            end
            rd_inflight <= ram_rd_en;

            case ({push, pop})
                2'b10: begin
                    if (skid_cnt == 2'd0) begin
                        skid_head <= ram_rd_data;
                    end else begin
                        skid_tail <= ram_rd_data;
                    end
                    skid_cnt <= skid_cnt + 2'd1;
                end
                2'b01: begin
                    skid_head <= skid_tail;
                    skid_cnt  <= skid_cnt - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; the landing word goes wherever the head/tail shift leaves room.
                    if (skid_cnt == 2'd1) begin
                        skid_head <= ram_rd_data;
                    end else begin
                        skid_head <= skid_tail;
                        skid_tail <= ram_rd_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full <= 1'b0;
        end else if (clr) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (ram_count >= (ADDR_W+1)'(AF_LEVEL));
        end
    end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural 16x8 RAM and a data scoreboard.
// Latency: accept sampled in cycle c must pop in cycle c+3 (valid after edge T+2) where checked.
// Backpressure: fill-to-full, hold-off, drain, stream, flush and (optionally) almost_full.
module tb_ram_fifo_ctrl;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int LAT    = 3;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic [ADDR_W+1:0] count;
`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
    logic              almost_full;
`endif

    ram_fifo_ctrl_if #(.DATA_W(DATA_W)) bus ();

    ram_fifo_ctrl #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .io         (bus.slave),
        .ram_wr_en  (ram_wr_en),
        .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data),
        .ram_rd_en  (ram_rd_en),
        .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data),
`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
        .almost_full(almost_full),
`endif
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write on port 0, registered read on port 1.
    logic [DATA_W-1:0] mem [0:15];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    int                n_err = 0;
    int                n_chk = 0;
    int                cyc   = 0;
    bit                lat_on;
    bit                acc;
    bit                popd;
    logic [DATA_W-1:0] exp_q [$];
    int                acc_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample handshakes at the falling edge, then step past the rising edge.
    task automatic tick();
        logic [DATA_W-1:0] e;
        int                c;
        @(negedge clk);
        acc  = bus.s_valid && bus.s_ready && !clr;
        popd = bus.m_valid && bus.m_ready;
        if (acc) begin
            exp_q.push_back(bus.s_data);
            acc_q.push_back(cyc);
        end
        if (popd) begin
            chk("sb_has_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                c = acc_q.pop_front();
                chk("out_data", 32'(bus.m_data), 32'(e));
                if (lat_on) chk("out_latency", 32'(cyc - c), 32'(LAT));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int limit, output int n);
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            tick();
            if (acc) bus.s_valid = 1'b0;
            n++;
        end
        chk("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        rst_n       = 1'b1;
        clr         = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        lat_on      = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_m_data",  32'(bus.m_data),  32'd0);
        chk("rst_count",   32'(count),       32'd0);
        chk("rst_wr_en",   32'(ram_wr_en),   32'd0);
        chk("rst_rd_en",   32'(ram_rd_en),   32'd0);
        chk("rst_addrs",   32'({ram_wr_addr, ram_rd_addr}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Fill with m_ready low: 16 words in RAM plus 2 pulled into the skid.
        for (int v = 1; v <= 18; v++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(v);
            n = 0;
            do begin tick(); n++; end while (!acc && n < 10);
            chk("fill_accept", 32'(acc), 32'd1);
            if (v == 16) begin
                chk("fill16_count",   32'(count),       32'd16);
                chk("fill16_s_ready", 32'(bus.s_ready), 32'd1);
            end
        end
        chk("full_s_ready", 32'(bus.s_ready), 32'd0);
        chk("full_count",   32'(count),       32'd18);
        bus.s_data = 8'h13;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("holdoff_acc",   32'(acc),       32'd0);
            chk("holdoff_wr_en", 32'(ram_wr_en), 32'd0);
        end
        chk("holdoff_count", 32'(count), 32'd18);

        // Drain: 18 stored words plus the held 0x13, back to back.
        bus.m_ready = 1'b1;
        drain(60, n);
        chk("drain_cycles",  32'(n),           32'd19);
        chk("drain_m_valid", 32'(bus.m_valid), 32'd0);
        chk("drain_count",   32'(count),       32'd0);

        // Single word latency.
        lat_on      = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hA5;
        tick();
        chk("single_acc", 32'(acc), 32'd1);
        bus.s_valid = 1'b0;
        chk("single_t0", 32'(bus.m_valid), 32'd0);
        tick();
        chk("single_t1", 32'(bus.m_valid), 32'd0);
        tick();
        chk("single_t2_valid", 32'(bus.m_valid), 32'd1);
        chk("single_t2_data",  32'(bus.m_data),  32'hA5);
        tick();
        chk("single_t3_valid", 32'(bus.m_valid), 32'd0);

        // 40-word stream: pointers wrap twice, every word exactly LAT cycles.
        for (int i = 0; i < 40; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'($urandom_range(0, 255));
            tick();
            chk("stream_acc", 32'(acc), 32'd1);
        end
        bus.s_valid = 1'b0;
        drain(20, n);
        chk("stream_count", 32'(count), 32'd0);

        // Flush with a concurrent write request.
        lat_on      = 1'b0;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(8'h40 + i);
            tick();
        end
        chk("pre_clr_count", 32'(count), 32'd10);
        clr         = 1'b1;
        bus.s_data  = 8'hEE;
        #1;
        chk("clr_wr_en", 32'(ram_wr_en), 32'd0);
        tick();
        clr         = 1'b0;
        bus.s_valid = 1'b0;
        exp_q.delete();
        acc_q.delete();
        chk("post_clr_m_valid", 32'(bus.m_valid), 32'd0);
        chk("post_clr_count",   32'(count),       32'd0);
        tick();
        chk("post_clr2_m_valid", 32'(bus.m_valid), 32'd0);
        chk("post_clr2_count",   32'(count),       32'd0);
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h33;
        tick();
        bus.s_valid = 1'b0;
        chk("clr_next_acc", 32'(acc), 32'd1);
        drain(10, n);
        chk("clr_next_count", 32'(count), 32'd0);

`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
        // With m_ready low the skid holds 2, so RAM holds n-2 after n writes.
        bus.m_ready = 1'b0;
        for (int w = 1; w <= 16; w++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(8'h80 + w);
            tick();
            bus.s_valid = 1'b0;
            repeat (3) tick();
            chk("af_fill", 32'(almost_full), 32'(((w > 2) ? w - 2 : 0) >= 12));
        end
        // Each pop pulls one word out of the RAM: 13, 12, 11, 10.
        for (int p = 1; p <= 4; p++) begin
            bus.m_ready = 1'b1;
            tick();
            bus.m_ready = 1'b0;
            repeat (3) tick();
            chk("af_drain", 32'(almost_full), 32'((14 - p) >= 12));
        end
        bus.m_ready = 1'b1;
        drain(30, n);
        chk("af_final", 32'(almost_full), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
